// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the pwm duty-cycle sequencer.
// Holds the pwm register map, the host register map and the FSM states.
package pwm_pkg;

    // pwm peripheral register offsets; channel 2 sits PWM_CH2_OFF above channel 1
    localparam logic [7:0] PWM_CTRL_OFF = 8'h00;
    localparam logic [7:0] PWM_DIV_OFF  = 8'h04;
    localparam logic [7:0] PWM_PER_OFF  = 8'h08;
    localparam logic [7:0] PWM_DC_OFF   = 8'h0C;
    localparam logic [7:0] PWM_CH2_OFF  = 8'h10;

    localparam logic [7:0] SEQ_CTRL       = 8'h00;
    localparam logic [7:0] SEQ_STATUS     = 8'h04;
    localparam logic [7:0] SEQ_DIVISOR    = 8'h08;
    localparam logic [7:0] SEQ_PERIOD     = 8'h0C;
    localparam logic [7:0] SEQ_STEP       = 8'h10;
    localparam logic [7:0] SEQ_LEN        = 8'h14;
    localparam logic [7:0] SEQ_TABLE_BASE = 8'h40;

    localparam int CTRL_START = 0;
    localparam int CTRL_LOOP  = 1;
    localparam int CTRL_CH    = 2;
    localparam int CTRL_ABORT = 3;

    typedef enum logic [2:0] {
        IDLE,
        CFG_DIV,
        CFG_PER,
        CFG_DC,
        CFG_EN,
        WAIT,
        UPD,
        ABRT
    } seq_state_e;

endpackage

// File: rtl/pwm_seq_ctrl.sv
// Host-programmed sequencer that configures one pwm channel and then steps its
// duty-cycle register through a table, one entry every STEP clocks.
module pwm_seq_ctrl
    import pwm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  w_en_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  pwm_w_en_o,
    output logic [ADDR_WIDTH-1:0] pwm_addr_o,
    output logic [DATA_WIDTH-1:0] pwm_wdata_o,
    output logic                  busy_o,
    output logic                  done_irq_o
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int LEN_W   = IDX_W + 1;
    localparam int TAB_END = int'(SEQ_TABLE_BASE) + 4 * DEPTH;

    logic [DATA_WIDTH-1:0] r_div, r_per, r_step, r_len;
    logic                  r_loop, r_ch;
    logic [DATA_WIDTH-1:0] r_table [DEPTH];

    seq_state_e            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_cnt;
    logic                  r_done, r_done_irq;
    logic [DATA_WIDTH-1:0] r_run_div, r_run_per, r_run_step_m2;
    logic [LEN_W-1:0]      r_run_len;
    logic                  r_run_loop, r_run_ch;

    logic                  w_ctrl_sel, w_status_sel, w_div_sel, w_per_sel;
    logic                  w_step_sel, w_len_sel, w_tab_sel;
    logic [IDX_W-1:0]      w_tab_idx;
    logic                  w_start, w_abort;
    logic [LEN_W-1:0]      w_len_eff, w_idx_inc;
    logic [DATA_WIDTH-1:0] w_step_m2;
    logic                  w_more, w_wrap;
    logic [ADDR_WIDTH-1:0] w_base;

    assign w_ctrl_sel   = (addr_i == ADDR_WIDTH'(SEQ_CTRL));
    assign w_status_sel = (addr_i == ADDR_WIDTH'(SEQ_STATUS));
    assign w_div_sel    = (addr_i == ADDR_WIDTH'(SEQ_DIVISOR));
    assign w_per_sel    = (addr_i == ADDR_WIDTH'(SEQ_PERIOD));
    assign w_step_sel   = (addr_i == ADDR_WIDTH'(SEQ_STEP));
    assign w_len_sel    = (addr_i == ADDR_WIDTH'(SEQ_LEN));
    assign w_tab_sel    = (addr_i[1:0] == 2'b00) && (int'(addr_i) >= int'(SEQ_TABLE_BASE))
                          && (int'(addr_i) < TAB_END);
    // Table base is aligned to the table size, so the low word-address bits are the index.
    assign w_tab_idx    = addr_i[IDX_W+1:2];

    assign w_start = w_en_i && w_ctrl_sel && wdata_i[CTRL_START];
    assign w_abort = w_en_i && w_ctrl_sel && wdata_i[CTRL_ABORT];

    always_comb begin
        if (r_len == '0) begin
            w_len_eff = LEN_W'(1);
        end else if (r_len > DATA_WIDTH'(DEPTH)) begin
            w_len_eff = LEN_W'(DEPTH);
        end else begin
            w_len_eff = r_len[LEN_W-1:0];
        end
    end

    assign w_step_m2 = (r_step < DATA_WIDTH'(2)) ? '0 : r_step - DATA_WIDTH'(2);
    assign w_idx_inc = LEN_W'(r_idx) + LEN_W'(1);
    assign w_more    = (w_idx_inc < r_run_len);
    assign w_wrap    = (r_run_len == LEN_W'(1)) || r_run_loop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_div  <= '0;
            r_per  <= '0;
            r_step <= '0;
            r_len  <= '0;
            r_loop <= 1'b0;
            r_ch   <= 1'b0;
            // NOTE: the table is a small flop array, so it is reset like any other register.
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (w_en_i) begin
            if (w_ctrl_sel) begin
                r_loop <= wdata_i[CTRL_LOOP];
                r_ch   <= wdata_i[CTRL_CH];
            end
            if (w_div_sel)  r_div  <= wdata_i;
            if (w_per_sel)  r_per  <= wdata_i;
            if (w_step_sel) r_step <= wdata_i;
            if (w_len_sel)  r_len  <= wdata_i;
            if (w_tab_sel)  r_table[w_tab_idx] <= wdata_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_done        <= 1'b0;
            r_done_irq    <= 1'b0;
            r_run_div     <= '0;
            r_run_per     <= '0;
            r_run_step_m2 <= '0;
            r_run_len     <= '0;
            r_run_loop    <= 1'b0;
            r_run_ch      <= 1'b0;
        end else begin
            r_done_irq <= 1'b0;
            if (r_state == IDLE) begin
                if (w_start && !w_abort) begin
                    r_state       <= CFG_DIV;
                    r_idx         <= '0;
                    r_done        <= 1'b0;
                    r_run_div     <= r_div;
                    r_run_per     <= r_per;
                    r_run_step_m2 <= w_step_m2;
                    r_run_len     <= w_len_eff;
                    r_run_loop    <= wdata_i[CTRL_LOOP];
                    r_run_ch      <= wdata_i[CTRL_CH];
                end
            end else if (w_abort && r_state != ABRT) begin
                r_state <= ABRT;
            end else begin
                case (r_state)
                    CFG_DIV: r_state <= CFG_PER;
                    CFG_PER: r_state <= CFG_DC;
                    CFG_DC:  r_state <= CFG_EN;
                    CFG_EN: begin
                        r_cnt   <= r_run_step_m2;
                        r_state <= WAIT;
                    end
                    WAIT: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - DATA_WIDTH'(1);
                        end else if (w_more) begin
                            r_idx   <= w_idx_inc[IDX_W-1:0];
                            r_state <= UPD;
                        end else if (w_wrap) begin
                            r_idx   <= '0;
                            r_state <= UPD;
                        end else begin
                            r_state    <= IDLE;
                            r_done     <= 1'b1;
                            r_done_irq <= 1'b1;
                        end
                    end
                    UPD: begin
                        r_cnt   <= w_step_m2;
                        r_state <= WAIT;
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_done     <= 1'b1;
                        r_done_irq <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign w_base = r_run_ch ? ADDR_WIDTH'(PWM_CH2_OFF) : '0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pwm_w_en_o  = 1'b0;
        pwm_addr_o  = '0;
        pwm_wdata_o = '0;
        case (r_state)
            CFG_DIV: begin
                pwm_w_en_o  = 1'b1;
                pwm_addr_o  = w_base + ADDR_WIDTH'(PWM_DIV_OFF);
                pwm_wdata_o = r_run_div;
            end
            CFG_PER: begin
                pwm_w_en_o  = 1'b1;
                pwm_addr_o  = w_base + ADDR_WIDTH'(PWM_PER_OFF);
                pwm_wdata_o = r_run_per;
            end
            CFG_DC: begin
                pwm_w_en_o  = 1'b1;
                pwm_addr_o  = w_base + ADDR_WIDTH'(PWM_DC_OFF);
                pwm_wdata_o = r_table[0];
            end
            CFG_EN: begin
                pwm_w_en_o  = 1'b1;
                pwm_addr_o  = w_base + ADDR_WIDTH'(PWM_CTRL_OFF);
                pwm_wdata_o = DATA_WIDTH'(3'b111);
            end
            UPD: begin
                pwm_w_en_o  = 1'b1;
                pwm_addr_o  = w_base + ADDR_WIDTH'(PWM_DC_OFF);
                pwm_wdata_o = r_table[r_idx];
            end
            ABRT: begin
                pwm_w_en_o  = 1'b1;
                pwm_addr_o  = w_base + ADDR_WIDTH'(PWM_CTRL_OFF);
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata_o = '0;
        if (rd_en_i) begin
            if (w_ctrl_sel) begin
                rdata_o[CTRL_LOOP] = r_loop;
                rdata_o[CTRL_CH]   = r_ch;
            end else if (w_status_sel) begin
                rdata_o[0]         = (r_state != IDLE);
                rdata_o[1]         = r_done;
                rdata_o[4 +: IDX_W] = r_idx;
            end else if (w_div_sel) begin
                rdata_o = r_div;
            end else if (w_per_sel) begin
                rdata_o = r_per;
            end else if (w_step_sel) begin
                rdata_o = r_step;
            end else if (w_len_sel) begin
                rdata_o = r_len;
            end else if (w_tab_sel) begin
                rdata_o = r_table[w_tab_idx];
            end
        end
    end

    assign busy_o     = (r_state != IDLE);
    assign done_irq_o = r_done_irq;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Scenario bench for pwm_seq_ctrl: expected pwm writes and done pulses are queued
// with their cycle numbers when stimulus is driven and matched as the DUT emits them.
module tb_pwm_seq_ctrl;
    import pwm_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 16;

    logic          clk_i   = 1'b0;
    logic          rst_ni  = 1'b1;
    logic          w_en_i  = 1'b0;
    logic          rd_en_i = 1'b0;
    logic [AW-1:0] addr_i  = '0;
    logic [DW-1:0] wdata_i = '0;
    logic [DW-1:0] rdata_o;
    logic          pwm_w_en_o;
    logic [AW-1:0] pwm_addr_o;
    logic [DW-1:0] pwm_wdata_o;
    logic          busy_o;
    logic          done_irq_o;

    pwm_seq_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .w_en_i     (w_en_i),
        .rd_en_i    (rd_en_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .pwm_w_en_o (pwm_w_en_o),
        .pwm_addr_o (pwm_addr_o),
        .pwm_wdata_o(pwm_wdata_o),
        .busy_o     (busy_o),
        .done_irq_o (done_irq_o)
    );

    typedef struct {
        int            at;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           wr_q[$];
    int            irq_q[$];
    int            cyc     = 0;
    int            n_tests = 0;
    int            n_fail  = 0;
    wr_t           mon_w;
    int            mon_i;
    logic [DW-1:0] exp_tab [DEPTH];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) step();
    endtask

    task automatic wr(input logic [7:0] a, input logic [DW-1:0] d);
        w_en_i  = 1'b1;
        addr_i  = a;
        wdata_i = d;
        step();
        w_en_i  = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [DW-1:0] d);
        rd_en_i = 1'b1;
        addr_i  = a;
        #1;
        d       = rdata_o;
        rd_en_i = 1'b0;
        addr_i  = '0;
    endtask

    task automatic push_wr(input int at, input logic [7:0] a, input logic [DW-1:0] d);
        wr_q.push_back('{at: at, addr: a, data: d});
    endtask

    task automatic push_cfg(input int t, input logic [7:0] base, input logic [DW-1:0] dc0);
        push_wr(t + 1, base + 8'h04, 32'd2);
        push_wr(t + 2, base + 8'h08, 32'd9);
        push_wr(t + 3, base + 8'h0C, dc0);
        push_wr(t + 4, base + 8'h00, 32'd7);
    endtask

    task automatic check_drained(input string name);
        n_tests++;
        if (wr_q.size() != 0 || irq_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s drained: %0d writes and %0d pulses still outstanding, required 0 and 0",
                     name, wr_q.size(), irq_q.size());
        end
        wr_q.delete();
        irq_q.delete();
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        #2 rst_ni = 1'b0;
        step();
        n_tests++;
        if ({pwm_w_en_o, busy_o, done_irq_o} !== 3'b000 || pwm_addr_o !== '0 || pwm_wdata_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b busy=%b irq=%b addr=0x%0h data=0x%0h, required all 0",
                     pwm_w_en_o, busy_o, done_irq_o, pwm_addr_o, pwm_wdata_o);
        end
        step();
        rst_ni = 1'b1;
        step();
        rd(SEQ_STATUS, d);
        n_tests++;
        if (d !== '0) begin n_fail++; $display("FAIL reset_status: got 0x%0h, required 0", d); end
        rd(SEQ_DIVISOR, d);
        n_tests++;
        if (d !== '0) begin n_fail++; $display("FAIL reset_divisor: got 0x%0h, required 0", d); end
    endtask

    task automatic test_regs();
        logic [DW-1:0] d;
        for (int i = 0; i < DEPTH; i++) exp_tab[i] = '0;
        exp_tab[0] = 32'd2; exp_tab[1] = 32'd5; exp_tab[2] = 32'd8; exp_tab[15] = 32'hF5;
        wr(SEQ_DIVISOR, 32'd2);
        wr(SEQ_PERIOD, 32'd9);
        wr(SEQ_STEP, 32'd5);
        wr(SEQ_LEN, 32'd3);
        wr(8'h40, exp_tab[0]);
        wr(8'h44, exp_tab[1]);
        wr(8'h48, exp_tab[2]);
        wr(8'h7C, exp_tab[15]);
        wr(8'h24, 32'hDEAD_BEEF);
        wr(SEQ_CTRL, 32'h6);
        rd(SEQ_CTRL, d);
        n_tests++;
        if (d !== 32'h6) begin n_fail++; $display("FAIL ctrl_readback: got 0x%0h, required 0x6", d); end
        wr(SEQ_CTRL, 32'h0);
        rd(8'h44, d);
        n_tests++;
        if (d !== 32'd5) begin n_fail++; $display("FAIL table1_readback: got 0x%0h, required 0x5", d); end
        rd(8'h7C, d);
        n_tests++;
        if (d !== 32'hF5) begin n_fail++; $display("FAIL table15_readback: got 0x%0h, required 0xf5", d); end
        rd(8'h24, d);
        n_tests++;
        if (d !== '0) begin n_fail++; $display("FAIL unmapped_read: got 0x%0h, required 0", d); end
        rd(8'h80, d);
        n_tests++;
        if (d !== '0) begin n_fail++; $display("FAIL past_table_read: got 0x%0h, required 0", d); end
        addr_i = SEQ_DIVISOR;
        #1;
        n_tests++;
        if (rdata_o !== '0) begin n_fail++; $display("FAIL rd_en_low: got 0x%0h, required 0", rdata_o); end
        addr_i = '0;
    endtask

    task automatic test_oneshot();
        logic [DW-1:0] d;
        int t;
        t = cyc;
        push_cfg(t, 8'h00, 32'd2);
        push_wr(t + 9, 8'h0C, 32'd5);
        push_wr(t + 14, 8'h0C, 32'd8);
        irq_q.push_back(t + 19);
        wr(SEQ_CTRL, 32'h1);
        to_cycle(t + 18);
        n_tests++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL oneshot_busy_high: got %b, required 1", busy_o); end
        to_cycle(t + 19);
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL oneshot_busy_fall: got %b, required 0", busy_o); end
        to_cycle(t + 21);
        rd(SEQ_STATUS, d);
        n_tests++;
        if (d !== 32'h22) begin n_fail++; $display("FAIL oneshot_status: got 0x%0h, required 0x22", d); end
        check_drained("oneshot");
    endtask

    task automatic test_loop_abort();
        logic [DW-1:0] d;
        int t, a;
        t = cyc;
        push_cfg(t, 8'h10, 32'd2);
        for (int k = 1; k <= 5; k++) push_wr(t + 4 + 5 * k, 8'h1C, exp_tab[k % 3]);
        wr(SEQ_CTRL, 32'h7);
        to_cycle(t + 31);
        n_tests++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL loop_busy: got %b, required 1", busy_o); end
        a = cyc;
        push_wr(a + 1, 8'h10, 32'd0);
        irq_q.push_back(a + 2);
        wr(SEQ_CTRL, 32'h8);
        to_cycle(a + 2);
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, required 0", busy_o); end
        to_cycle(a + 4);
        rd(SEQ_STATUS, d);
        n_tests++;
        if (d !== 32'h22) begin n_fail++; $display("FAIL abort_status: got 0x%0h, required 0x22", d); end
        check_drained("loop_abort");
    endtask

    task automatic test_idle_abort();
        logic [DW-1:0] d;
        wr(SEQ_CTRL, 32'h8);
        to_cycle(cyc + 5);
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL idle_abort_busy: got %b, required 0", busy_o); end
        rd(SEQ_STATUS, d);
        n_tests++;
        if (d !== 32'h22) begin n_fail++; $display("FAIL idle_abort_status: got 0x%0h, required 0x22", d); end
        check_drained("idle_abort");
    endtask

    task automatic test_min_step_len();
        logic [DW-1:0] d;
        int t, a;
        wr(SEQ_STEP, 32'd0);
        wr(SEQ_LEN, 32'd0);
        t = cyc;
        push_cfg(t, 8'h00, 32'd2);
        push_wr(t + 6, 8'h0C, 32'd2);
        for (int k = 8; k <= 12; k += 2) push_wr(t + k, 8'h0C, 32'h33);
        wr(SEQ_CTRL, 32'h1);
        to_cycle(t + 2);
        rd(SEQ_STATUS, d);
        n_tests++;
        if (d !== 32'h01) begin n_fail++; $display("FAIL start_clears_done: got 0x%0h, required 0x1", d); end
        to_cycle(t + 7);
        wr(8'h40, 32'h33);
        to_cycle(t + 13);
        a = cyc;
        push_wr(a + 1, 8'h00, 32'd0);
        irq_q.push_back(a + 2);
        wr(SEQ_CTRL, 32'h8);
        to_cycle(a + 4);
        rd(SEQ_STATUS, d);
        n_tests++;
        if (d !== 32'h02) begin n_fail++; $display("FAIL min_abort_status: got 0x%0h, required 0x2", d); end
        wr(8'h40, 32'd2);
        check_drained("min_step_len");
    endtask

    task automatic test_len_clamp();
        logic [DW-1:0] d;
        int t;
        wr(SEQ_STEP, 32'd2);
        wr(SEQ_LEN, 32'd40);
        t = cyc;
        push_cfg(t, 8'h00, exp_tab[0]);
        for (int k = 1; k < DEPTH; k++) push_wr(t + 4 + 2 * k, 8'h0C, exp_tab[k]);
        irq_q.push_back(t + 36);
        wr(SEQ_CTRL, 32'h1);
        to_cycle(t + 38);
        rd(SEQ_STATUS, d);
        n_tests++;
        if (d !== 32'hF2) begin n_fail++; $display("FAIL clamp_status: got 0x%0h, required 0xf2", d); end
        check_drained("len_clamp");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        int t, a;
        wr(SEQ_STEP, 32'd5);
        wr(SEQ_LEN, 32'd3);
        t = cyc;
        push_cfg(t, 8'h00, 32'd2);
        push_wr(t + 9, 8'h0C, 32'd5);
        push_wr(t + 14, 8'h0C, 32'd8);
        wr(SEQ_CTRL, 32'h1);
        to_cycle(t + 6);
        wr(SEQ_CTRL, 32'h1);
        to_cycle(t + 16);
        a = cyc;
        push_wr(a + 1, 8'h00, 32'd0);
        irq_q.push_back(a + 2);
        wr(SEQ_CTRL, 32'h9);
        to_cycle(a + 4);
        rd(SEQ_STATUS, d);
        n_tests++;
        if (d !== 32'h22) begin n_fail++; $display("FAIL b2b_status: got 0x%0h, required 0x22", d); end
        check_drained("back_to_back");
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        int t;
        t = cyc;
        push_wr(t + 1, 8'h04, 32'd2);
        wr(SEQ_CTRL, 32'h1);
        to_cycle(t + 2);
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if (pwm_w_en_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: got en=%b busy=%b, required 0 and 0", pwm_w_en_o, busy_o);
        end
        n_tests++;
        if (pwm_addr_o !== '0 || pwm_wdata_o !== '0) begin
            n_fail++;
            $display("FAIL midreset_bus: got addr=0x%0h data=0x%0h, required 0 and 0", pwm_addr_o, pwm_wdata_o);
        end
        step();
        step();
        rst_ni = 1'b1;
        to_cycle(cyc + 4);
        rd(SEQ_DIVISOR, d);
        n_tests++;
        if (d !== '0) begin n_fail++; $display("FAIL midreset_divisor: got 0x%0h, required 0", d); end
        rd(8'h48, d);
        n_tests++;
        if (d !== '0) begin n_fail++; $display("FAIL midreset_table: got 0x%0h, required 0", d); end
        rd(SEQ_STATUS, d);
        n_tests++;
        if (d !== '0) begin n_fail++; $display("FAIL midreset_status: got 0x%0h, required 0", d); end
        check_drained("reset_mid");
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk_i);
                if (pwm_w_en_o === 1'b1) begin
                    n_tests++;
                    if (wr_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL pwm_write: got cyc=%0d addr=0x%0h data=0x%0h, required no write",
                                 cyc, pwm_addr_o, pwm_wdata_o);
                    end else begin
                        mon_w = wr_q.pop_front();
                        if (mon_w.at != cyc || mon_w.addr !== pwm_addr_o || mon_w.data !== pwm_wdata_o) begin
                            n_fail++;
                            $display("FAIL pwm_write: got cyc=%0d addr=0x%0h data=0x%0h, required cyc=%0d addr=0x%0h data=0x%0h",
                                     cyc, pwm_addr_o, pwm_wdata_o, mon_w.at, mon_w.addr, mon_w.data);
                        end
                    end
                end else if (wr_q.size() != 0 && wr_q[0].at <= cyc) begin
                    mon_w = wr_q.pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL pwm_write: got none at cyc=%0d, required addr=0x%0h data=0x%0h",
                             cyc, mon_w.addr, mon_w.data);
                end
                if (done_irq_o === 1'b1) begin
                    n_tests++;
                    if (irq_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL done_irq: got pulse at cyc=%0d, required none", cyc);
                    end else begin
                        mon_i = irq_q.pop_front();
                        if (mon_i != cyc) begin
                            n_fail++;
                            $display("FAIL done_irq: got pulse at cyc=%0d, required cyc=%0d", cyc, mon_i);
                        end
                    end
                end else if (irq_q.size() != 0 && irq_q[0] <= cyc) begin
                    mon_i = irq_q.pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL done_irq: got no pulse, required cyc=%0d", mon_i);
                end
            end
        join_none

        test_reset();
        test_regs();
        test_oneshot();
        test_loop_abort();
        test_idle_abort();
        test_min_step_len();
        test_len_clamp();
        test_back_to_back();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
